// File: rtl/vga_board_render_ctrl.sv
// vga_board_render_ctrl
// Walks the cell board once per frame and paints every cell as a CELL_PX x CELL_PX
// block of pixels on a ready/valid plot port. Frames are either free-running with an
// idle gap of WAIT_CYCLES, or single-stepped while enable is low.
module vga_board_render_ctrl #(
    parameter int BOARD_W              = 16,
    parameter int BOARD_H              = 16,
    parameter int CELL_PX              = 4,
    parameter int WAIT_CYCLES          = 1000,
    parameter int COLOR_W              = 3,
    parameter logic [COLOR_W-1:0] ALIVE_COLOR = 3'b111,
    parameter logic [COLOR_W-1:0] DEAD_COLOR  = 3'b000,
    localparam int CX_W = (BOARD_W > 1) ? $clog2(BOARD_W) : 1,
    localparam int CY_W = (BOARD_H > 1) ? $clog2(BOARD_H) : 1,
    localparam int PX_W = (BOARD_W * CELL_PX > 1) ? $clog2(BOARD_W * CELL_PX) : 1,
    localparam int PY_W = (BOARD_H * CELL_PX > 1) ? $clog2(BOARD_H * CELL_PX) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               step,
    input  logic               cell_alive,
    input  logic               plot_ready,
    output logic [CX_W-1:0]    cell_x,
    output logic [CY_W-1:0]    cell_y,
    output logic               save_board,
    output logic               plot,
    output logic [PX_W-1:0]    pix_x,
    output logic [PY_W-1:0]    pix_y,
    output logic [COLOR_W-1:0] colour,
    output logic               waiting,
    output logic               frame_done
);

    localparam int SUB_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam int WC_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_SAVE  = 3'd1,
        S_FETCH = 3'd2,
        S_LATCH = 3'd3,
        S_PLOT  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic [CX_W-1:0]    cx_q, cx_d;
    logic [CY_W-1:0]    cy_q, cy_d;
    logic [SUB_W-1:0]   sx_q, sx_d;
    logic [SUB_W-1:0]   sy_q, sy_d;
    logic [COLOR_W-1:0] colour_q, colour_d;
    logic               frame_done_q, frame_done_d;

    logic handshake;
    logic last_sx, last_sy, last_cx, last_cy;
    logic last_pix, last_cell;
    logic wait_go;

    // Decode of counter end points and the frame-start condition.
    always_comb begin
        handshake = (state_q == S_PLOT) && plot_ready;
        last_sx   = (sx_q == SUB_W'(CELL_PX - 1));
        last_sy   = (sy_q == SUB_W'(CELL_PX - 1));
        last_cx   = (cx_q == CX_W'(BOARD_W - 1));
        last_cy   = (cy_q == CY_W'(BOARD_H - 1));
        last_pix  = last_sx && last_sy;
        last_cell = last_cx && last_cy;
        wait_go   = (state_q == S_WAIT) &&
                    ((enable && (wcnt_q == WC_W'(WAIT_CYCLES - 1))) || (!enable && step));
    end

    // State and datapath registers; asynchronous reset returns to an idle WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_WAIT;
            wcnt_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            colour_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            colour_q     <= colour_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: snapshot, then fetch/latch/plot per cell until the last cell.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (wait_go) state_d = S_SAVE;
            S_SAVE:  state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = S_PLOT;
            S_PLOT: begin
                if (handshake && last_pix) begin
                    state_d = last_cell ? S_WAIT : S_FETCH;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Counter and colour updates; sub-pixels advance only on an accepted pixel.
    always_comb begin
        wcnt_d       = '0;
        cx_d         = cx_q;
        cy_d         = cy_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        colour_d     = colour_q;
        frame_done_d = handshake && last_pix && last_cell;

        if (state_q == S_WAIT && !wait_go && enable) begin
            wcnt_d = wcnt_q + WC_W'(1);
        end

        if (state_q == S_SAVE) begin
            cx_d = '0;
            cy_d = '0;
            sx_d = '0;
            sy_d = '0;
        end

        if (state_q == S_LATCH) begin
            colour_d = cell_alive ? ALIVE_COLOR : DEAD_COLOR;
        end

        if (handshake) begin
            if (last_sx) begin
                sx_d = '0;
                if (last_sy) begin
                    sy_d = '0;
                    if (last_cx) begin
                        cx_d = '0;
                        cy_d = last_cy ? '0 : cy_q + CY_W'(1);
                    end else begin
                        cx_d = cx_q + CX_W'(1);
                    end
                end else begin
                    sy_d = sy_q + SUB_W'(1);
                end
            end else begin
                sx_d = sx_q + SUB_W'(1);
            end
        end
    end

    // Output decode: strobes from state, pixel position from cell and sub-pixel counters.
    always_comb begin
        waiting    = (state_q == S_WAIT);
        save_board = (state_q == S_SAVE);
        plot       = (state_q == S_PLOT);
        frame_done = frame_done_q;
        colour     = colour_q;
        cell_x     = cx_q;
        cell_y     = cy_q;
        pix_x      = PX_W'(cx_q) * PX_W'(CELL_PX) + PX_W'(sx_q);
        pix_y      = PY_W'(cy_q) * PY_W'(CELL_PX) + PY_W'(sy_q);
    end

endmodule

// File: tb/tb_vga_board_render_ctrl.sv
// Testbench for vga_board_render_ctrl on a 2x2 board of 2x2-pixel cells.
// A reference model expands each board into its expected pixel stream; a monitor
// pops and compares one entry per accepted pixel.
module tb_vga_board_render_ctrl;

    localparam int BW = 2;
    localparam int BH = 2;
    localparam int CP = 2;
    localparam int WC = 5;
    localparam int FRAME_LAT = 1 + BW * BH * (2 + CP * CP);

    logic       clk;
    logic       resetn;
    logic       enable;
    logic       step;
    logic       cell_alive;
    logic       plot_ready;
    logic [0:0] cell_x;
    logic [0:0] cell_y;
    logic       save_board;
    logic       plot;
    logic [1:0] pix_x;
    logic [1:0] pix_y;
    logic [2:0] colour;
    logic       waiting;
    logic       frame_done;

    vga_board_render_ctrl #(
        .BOARD_W    (BW),
        .BOARD_H    (BH),
        .CELL_PX    (CP),
        .WAIT_CYCLES(WC),
        .COLOR_W    (3),
        .ALIVE_COLOR(3'b111),
        .DEAD_COLOR (3'b000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .step      (step),
        .cell_alive(cell_alive),
        .plot_ready(plot_ready),
        .cell_x    (cell_x),
        .cell_y    (cell_y),
        .save_board(save_board),
        .plot      (plot),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .colour    (colour),
        .waiting   (waiting),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board memory: live contents, the snapshot taken on save_board, registered read.
    bit live [BH][BW];
    bit snap [BH][BW];
    always @(posedge clk) begin
        if (save_board) snap <= live;
        cell_alive <= snap[cell_y][cell_x];
    end

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;
    px_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int save_cnt = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int save_ncyc = 0;
    bit lat_en = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference model: cells row-major, pixels row-major within a cell.
    task automatic push_frame();
        for (int cy = 0; cy < BH; cy++)
            for (int cx = 0; cx < BW; cx++)
                for (int sy = 0; sy < CP; sy++)
                    for (int sx = 0; sx < CP; sx++)
                        exp_q.push_back('{cx * CP + sx, cy * CP + sy, live[cy][cx] ? 7 : 0});
    endtask

    task automatic rand_board();
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                live[y][x] = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            if (rnd) plot_ready = 1'($urandom_range(0, 1));
            n++;
        end
        plot_ready = 1'b1;
        chk("frame_done_seen", int'(done_cnt != d0), 1);
    endtask

    // Monitor: scoreboard pops on every accepted pixel; also tracks strobes and stalls.
    initial begin
        bit  stall;
        int  hx, hy, hc;
        px_t e;
        stall = 0;
        hx = 0; hy = 0; hc = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!resetn) begin
                stall = 0;
            end else begin
                if (save_board) begin
                    save_cnt++;
                    save_ncyc = ncyc;
                end
                if (frame_done) begin
                    done_cnt++;
                    if (lat_en) chk("frame_latency", ncyc - save_ncyc, FRAME_LAT);
                end
                if (stall && plot) begin
                    checks++;
                    if (int'(pix_x) != hx || int'(pix_y) != hy || int'(colour) != hc) begin
                        errors++;
                        $display("FAIL stall_hold: got (%0d,%0d) c=%0d required (%0d,%0d) c=%0d",
                                 pix_x, pix_y, colour, hx, hy, hc);
                    end
                end
                if (plot && plot_ready) begin
                    hs_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pixel_unexpected: got (%0d,%0d) c=%0d required none",
                                 pix_x, pix_y, colour);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(pix_x) != e.x || int'(pix_y) != e.y || int'(colour) != e.c) begin
                            errors++;
                            $display("FAIL pixel: got (%0d,%0d) c=%0d required (%0d,%0d) c=%0d",
                                     pix_x, pix_y, colour, e.x, e.y, e.c);
                        end
                    end
                end
                stall = plot && !plot_ready;
                hx = int'(pix_x);
                hy = int'(pix_y);
                hc = int'(colour);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, h0, rel, n;
        resetn = 1'b1;
        enable = 1'b1;
        step = 1'b0;
        plot_ready = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_waiting", int'(waiting), 1);
        chk("rst_plot", int'(plot), 0);
        chk("rst_save", int'(save_board), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_pix", int'({pix_x, pix_y}), 0);

        // Free-running first frame, only cell (1,0) alive
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                live[y][x] = 1'b0;
        live[0][1] = 1'b1;
        push_frame();
        lat_en = 1;
        h0 = hs_cnt;
        s0 = save_cnt;
        rel = ncyc;
        resetn = 1'b1;
        n = 0;
        while (save_cnt == s0 && n < 20) begin
            tick();
            n++;
        end
        // First WAIT cycle is sampled at rel+1; save follows WAIT_CYCLES later.
        chk("save_delay", save_ncyc - rel, 1 + WC);
        wait_done(0, 100);
        enable = 1'b0;
        lat_en = 0;
        chk("t1_handshakes", hs_cnt - h0, 16);
        chk("t1_waiting", int'(waiting), 1);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Backpressure on the first pixel
        rand_board();
        push_frame();
        plot_ready = 1'b0;
        pulse_step();
        n = 0;
        while (!plot && n < 10) begin
            tick();
            n++;
        end
        repeat (3) begin
            chk("stall_plot", int'(plot), 1);
            chk("stall_pix", int'({pix_x, pix_y}), 0);
            tick();
        end
        plot_ready = 1'b1;
        wait_done(0, 100);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Single step, second step mid-frame ignored
        rand_board();
        push_frame();
        s0 = save_cnt;
        d0 = done_cnt;
        h0 = hs_cnt;
        pulse_step();
        n = 0;
        while (hs_cnt < h0 + 6 && n < 50) begin
            tick();
            n++;
        end
        pulse_step();
        wait_done(0, 100);
        repeat (40) tick();
        chk("t4_saves", save_cnt - s0, 1);
        chk("t4_dones", done_cnt - d0, 1);
        chk("t4_queue_empty", exp_q.size(), 0);
        chk("t4_waiting", int'(waiting), 1);

        // Asynchronous reset mid-PLOT at pixel (1,1)
        rand_board();
        push_frame();
        pulse_step();
        n = 0;
        while (!(plot && pix_x == 2'd1 && pix_y == 2'd1) && n < 50) begin
            tick();
            n++;
        end
        chk("t5_reached_11", int'(plot && pix_x == 2'd1 && pix_y == 2'd1), 1);
        resetn = 1'b0;
        #1;
        chk("t5_plot", int'(plot), 0);
        chk("t5_waiting", int'(waiting), 1);
        chk("t5_colour", int'(colour), 0);
        chk("t5_pix", int'({pix_x, pix_y}), 0);
        chk("t5_cell", int'({cell_x, cell_y}), 0);
        exp_q.delete();
        tick();
        resetn = 1'b1;
        tick();
        rand_board();
        push_frame();
        pulse_step();
        wait_done(0, 100);
        chk("t5_queue_empty", exp_q.size(), 0);

        // enable dropped after 5 pixels
        rand_board();
        push_frame();
        s0 = save_cnt;
        h0 = hs_cnt;
        enable = 1'b1;
        n = 0;
        while (hs_cnt < h0 + 5 && n < 50) begin
            tick();
            n++;
        end
        enable = 1'b0;
        wait_done(0, 100);
        repeat (30) tick();
        chk("t6_saves", save_cnt - s0, 1);
        chk("t6_handshakes", hs_cnt - h0, 16);
        chk("t6_queue_empty", exp_q.size(), 0);

        // Random boards under random backpressure
        for (int f = 0; f < 6; f++) begin
            rand_board();
            push_frame();
            pulse_step();
            wait_done(1, 500);
            chk("rand_queue_empty", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
